mult_acc_40_signed: RTL and testbench
=====================================

Name: mult_acc_40_signed

Overview:
- Downstream consumer of the 20x20 signed pipelined multiplier.
- Accumulates a framed sequence of 40-bit signed products into a wider signed sum, saturating on overflow.
- Presents each completed sum on a valid/ready output register.
- Sits between the multiplier Result port and the result-collection logic of the dot-product datapath.

Parameters:
WIDTHP, 40, product width; must match multiplier lpm_widthp
WIDTHS, 48, accumulator/sum width (WIDTHS > WIDTHP)
CNTW, 16, term-counter width
SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap (overflow still flagged)

Ports:
Clock  in  1  rising-edge clock, shared with the multiplier
Aclr  in  1  reset, synchronous, active-high (port name kept for consistency with the multiplier)
Product  in  WIDTHP  signed product from multiplier Result
ProdValid  in  1  Product is valid this cycle (multiplier input valid delayed by lpm_pipeline)
First  in  1  qualifies ProdValid: first term of a sequence
Last  in  1  qualifies ProdValid: final term of a sequence
Sum  out  WIDTHS  signed completed sum
Count  out  CNTW  number of terms in Sum
SumValid  out  1  Sum/Count hold a result not yet accepted
SumReady  in  1  consumer accepts Sum when SumValid & SumReady
Ovf  out  1  sticky: saturation/wrap occurred in any sequence
Overrun  out  1  sticky: an unaccepted result was overwritten
SeqErr  out  1  sticky: framing error
ClrFlags  in  1  synchronous clear of Ovf, Overrun and SeqErr

Behaviour:
- Reset: while Aclr is high at a clock edge, all registers are cleared.
  - Sum=0, Count=0, SumValid=0, Ovf=0, Overrun=0, SeqErr=0.
  - Internal Acc=0, TermCnt=0, state IDLE.
  - Reset overrides all other inputs, including a sequence in progress.
- States:
  - IDLE: no open sequence.
  - ACC: sequence open.
- Term value P = sign-extend(Product) to WIDTHS. Next value N:
  - First=1: N = P.
  - First=0: N = Acc + P, computed in WIDTHS+1 bits.
- Overflow: the top two bits of the WIDTHS+1 result differ.
  - Sets Ovf.
  - SATURATE=1: N clamps to +2^(WIDTHS-1)-1 or -2^(WIDTHS-1).
  - SATURATE=0: N keeps its low WIDTHS bits.
- Term counter: Tn = 1 if First, else TermCnt+1. Tn saturates at all-ones.
- Transitions, applied only when ProdValid=1 (ProdValid=0 holds all state):
  - IDLE, First=1, Last=0: Acc<=N, TermCnt<=Tn, go to ACC.
  - IDLE, First=1, Last=1: single-term result; emit N, stay IDLE.
  - IDLE, First=0: term is dropped, SeqErr<=1, stay IDLE.
  - ACC, First=0, Last=0: Acc<=N, TermCnt<=Tn.
  - ACC, First=0, Last=1: emit N, Acc<=0, go to IDLE.
  - ACC, First=1: the open sequence is abandoned and SeqErr<=1; a new sequence starts per the IDLE rules with First=1.
- Emit: Sum<=N, Count<=Tn, SumValid<=1 at the same clock edge.
  - Latency: Sum is visible 1 cycle after the Last term is presented.
- Output handshake:
  - Acceptance occurs when SumValid=1 and SumReady=1 at a clock edge. SumValid falls next cycle unless a new emit happens at that edge.
  - While SumValid=1 and not accepted, Sum and Count are held stable.
  - Emit with SumValid=1 and SumReady=0: new result overwrites the old one, Overrun<=1, SumValid stays 1.
  - Emit at the same edge as an acceptance: new result loads, SumValid stays 1, no Overrun.
  - SumReady while SumValid=0 is ignored.
- Flags:
  - Ovf, Overrun and SeqErr are sticky until Aclr, or ClrFlags is high at a clock edge.
  - If ClrFlags and a flag-setting event occur in the same cycle, the set wins.
- Ovf is a flag only. The saturated/wrapped value continues to accumulate and is emitted normally.

Test Plan:
- Reset mid-sequence: First term 5, then Aclr=1 for 1 cycle, then term First=0 value 7 -> SeqErr=1, SumValid=0, Sum=0.
- Basic sequence 3, -10, 100 (First on 3, Last on 100) with SumReady=1 -> SumValid pulses 1 cycle after the Last term, Sum=93, Count=3.
- Single term First&Last, Product=-2^39 -> Sum=0xFF_8000_0000_00 (sign-extended), Count=1.
- Saturation: Product=+2^39-1 repeated 300 terms, SATURATE=1 -> Sum=0x7FFF_FFFF_FFFF, Ovf=1. Then ClrFlags -> Ovf=0.
- Backpressure: two 1-term sequences (values 4, 9) on consecutive cycles, SumReady=0 -> Sum=9, Overrun=1, SumValid=1 until SumReady is raised, then falls next cycle.
- Accept-and-emit coincidence: raise SumReady in the cycle the second Last arrives -> Sum updates to the second value, SumValid stays 1, Overrun=0.
- Framing: First arrives while ACC with Acc=50, new term 8 -> SeqErr=1, Acc=8, TermCnt=1.

Source files
------------

// File: rtl/mult_acc_40_signed.sv
// mult_acc_40_signed: framed saturating accumulator of signed multiplier products,
// presenting each completed sum on a valid/ready output register with sticky status flags
module mult_acc_40_signed #(
  parameter int WIDTHP = 40,
  parameter int WIDTHS = 48,
  parameter int CNTW = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic Clock,
  input  logic Aclr,
  input  logic [WIDTHP-1:0] Product,
  input  logic ProdValid,
  input  logic First,
  input  logic Last,
  output logic [WIDTHS-1:0] Sum,
  output logic [CNTW-1:0] Count,
  output logic SumValid,
  input  logic SumReady,
  output logic Ovf,
  output logic Overrun,
  output logic SeqErr,
  input  logic ClrFlags
);
  localparam logic IDLE = 1'b0;
  localparam logic ACC = 1'b1;
  logic state;
  logic [WIDTHS-1:0] acc, p, base, n;
  logic [WIDTHS:0] wide;
  logic [CNTW-1:0] term_cnt, tn;
  logic ovf_raw, take, emit;
  always_comb begin
    p = {{(WIDTHS-WIDTHP){Product[WIDTHP-1]}}, Product};
    base = First ? '0 : acc;
    wide = {base[WIDTHS-1], base} + {p[WIDTHS-1], p};
    ovf_raw = wide[WIDTHS] ^ wide[WIDTHS-1];
    // clamp toward the sign of the true (WIDTHS+1)-bit result
    n = (SATURATE && ovf_raw) ? {wide[WIDTHS], {(WIDTHS-1){~wide[WIDTHS]}}} : wide[WIDTHS-1:0];
    tn = First ? CNTW'(1) : term_cnt + CNTW'(!(&term_cnt));
    take = ProdValid && (First || state == ACC);
    emit = take && Last;
  end
  always_ff @(posedge Clock) begin
    if (Aclr) begin
      state <= IDLE;
      acc <= '0;
      term_cnt <= '0;
      Sum <= '0;
      Count <= '0;
      SumValid <= 1'b0;
      Ovf <= 1'b0;
      Overrun <= 1'b0;
      SeqErr <= 1'b0;
    end else begin
      if (take) begin
        state <= Last ? IDLE : ACC;
        acc <= Last ? '0 : n;
        term_cnt <= tn;
      end
      if (emit) begin
        Sum <= n;
        Count <= tn;
        SumValid <= 1'b1;
      end else if (SumReady) SumValid <= 1'b0;
      Ovf <= (take && ovf_raw) || (Ovf && !ClrFlags);
      Overrun <= (emit && SumValid && !SumReady) || (Overrun && !ClrFlags);
      SeqErr <= (ProdValid && (First ? state == ACC : state == IDLE)) || (SeqErr && !ClrFlags);
    end
  end
endmodule

// File: tb/tb_mult_acc_40_signed.sv
// tb_mult_acc_40_signed: directed vector table, corner sequences and random traffic
// checked against an arithmetic model of the accumulator
module tb_mult_acc_40_signed;
  localparam longint MAXV = (64'sd1 <<< 47) - 1;
  localparam longint MINV = -(64'sd1 <<< 47);
  localparam longint MAXP = (64'sd1 <<< 39) - 1;
  localparam longint MINP = -(64'sd1 <<< 39);
  logic Clock = 1'b0;
  logic Aclr, ProdValid, First, Last, SumReady, ClrFlags;
  logic [39:0] Product;
  logic [47:0] Sum;
  logic [15:0] Count;
  logic SumValid, Ovf, Overrun, SeqErr;
  int checks = 0;
  int errors = 0;
  bit m_open, m_valid, m_ovf, m_ovr, m_serr;
  longint m_acc, m_sum;
  int m_cnt, m_count;

  mult_acc_40_signed dut (
    .Clock(Clock), .Aclr(Aclr), .Product(Product), .ProdValid(ProdValid),
    .First(First), .Last(Last), .Sum(Sum), .Count(Count), .SumValid(SumValid),
    .SumReady(SumReady), .Ovf(Ovf), .Overrun(Overrun), .SeqErr(SeqErr),
    .ClrFlags(ClrFlags)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input bit a, pv, f, l, rdy, clr, input longint p);
    longint nv = 0;
    int nc = 0;
    bit emit = 0, oe = 0, ov = 0, se = 0;
    if (a) begin
      m_open = 0; m_acc = 0; m_cnt = 0; m_sum = 0; m_count = 0;
      m_valid = 0; m_ovf = 0; m_ovr = 0; m_serr = 0;
      return;
    end
    if (pv) begin
      if (!f && !m_open) se = 1;
      else begin
        se = f && m_open;
        nv = f ? p : m_acc + p;
        nc = f ? 1 : (m_cnt >= 65535 ? 65535 : m_cnt + 1);
        if (nv > MAXV) begin nv = MAXV; ov = 1; end
        else if (nv < MINV) begin nv = MINV; ov = 1; end
        m_cnt = nc;
        if (l) begin emit = 1; m_open = 0; m_acc = 0; end
        else begin m_open = 1; m_acc = nv; end
      end
    end
    if (emit) begin
      oe = m_valid && !rdy;
      m_sum = nv; m_count = nc; m_valid = 1;
    end else if (m_valid && rdy) m_valid = 0;
    m_ovf = ov || (m_ovf && !clr);
    m_ovr = oe || (m_ovr && !clr);
    m_serr = se || (m_serr && !clr);
  endtask

  task automatic step(input bit a, pv, f, l, rdy, clr, input longint p);
    Aclr = a; ProdValid = pv; First = f; Last = l; SumReady = rdy; ClrFlags = clr;
    Product = p[39:0];
    @(posedge Clock);
    #1;
    model(a, pv, f, l, rdy, clr, p);
    chk("sum", longint'($signed(Sum)), m_sum);
    chk("count", longint'(Count), longint'(m_count));
    chk("sum_valid", longint'(SumValid), longint'(m_valid));
    chk("ovf", longint'(Ovf), longint'(m_ovf));
    chk("overrun", longint'(Overrun), longint'(m_ovr));
    chk("seq_err", longint'(SeqErr), longint'(m_serr));
  endtask

  typedef struct {
    bit a, pv, f, l, rdy, clr;
    longint prod;
    longint esum;
    int ecnt;
    bit ev, eovf, eovr, eserr;
  } vec_t;

  vec_t tbl[23];

  initial begin
    tbl = '{
      '{0,1,1,0,1,0,  5,    0,0,0,0,0,0},
      '{1,0,0,0,0,0,  0,    0,0,0,0,0,0},
      '{0,1,0,0,0,0,  7,    0,0,0,0,0,1},
      '{0,0,0,0,0,1,  0,    0,0,0,0,0,0},
      '{0,1,1,0,1,0,  3,    0,0,0,0,0,0},
      '{0,1,0,0,1,0,-10,    0,0,0,0,0,0},
      '{0,1,0,1,1,0,100,   93,3,1,0,0,0},
      '{0,0,0,0,1,0,  0,   93,3,0,0,0,0},
      '{0,1,1,1,0,0,MINP, MINP,1,1,0,0,0},
      '{0,0,0,0,1,0,  0, MINP,1,0,0,0,0},
      '{0,1,1,1,0,0,  4,    4,1,1,0,0,0},
      '{0,1,1,1,0,0,  9,    9,1,1,0,1,0},
      '{0,0,0,0,0,0,  0,    9,1,1,0,1,0},
      '{0,0,0,0,1,0,  0,    9,1,0,0,1,0},
      '{0,0,0,0,0,1,  0,    9,1,0,0,0,0},
      '{0,1,1,1,0,0,  4,    4,1,1,0,0,0},
      '{0,1,1,1,1,0,  9,    9,1,1,0,0,0},
      '{0,0,0,0,1,0,  0,    9,1,0,0,0,0},
      '{0,1,1,0,1,0, 20,    9,1,0,0,0,0},
      '{0,1,0,0,1,0, 30,    9,1,0,0,0,0},
      '{0,1,1,0,1,0,  8,    9,1,0,0,0,1},
      '{0,1,0,1,1,0,  0,    8,2,1,0,0,1},
      '{0,0,0,0,1,1,  0,    8,2,0,0,0,0}
    };
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].a, tbl[i].pv, tbl[i].f, tbl[i].l, tbl[i].rdy, tbl[i].clr, tbl[i].prod);
      chk($sformatf("tbl%0d_sum", i), longint'($signed(Sum)), tbl[i].esum);
      chk($sformatf("tbl%0d_count", i), longint'(Count), longint'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_valid", i), longint'(SumValid), longint'(tbl[i].ev));
      chk($sformatf("tbl%0d_ovf", i), longint'(Ovf), longint'(tbl[i].eovf));
      chk($sformatf("tbl%0d_overrun", i), longint'(Overrun), longint'(tbl[i].eovr));
      chk($sformatf("tbl%0d_seqerr", i), longint'(SeqErr), longint'(tbl[i].eserr));
    end
    // flag set and clear in the same cycle: set wins
    step(0, 1, 0, 0, 1, 1, 5);
    chk("set_beats_clr", longint'(SeqErr), 1);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("seqerr_cleared", longint'(SeqErr), 0);
    // positive saturation over 300 terms
    step(0, 1, 1, 0, 1, 0, MAXP);
    for (int i = 0; i < 298; i++) step(0, 1, 0, 0, 1, 0, MAXP);
    step(0, 1, 0, 1, 1, 0, MAXP);
    chk("sat_pos_sum", longint'($signed(Sum)), MAXV);
    chk("sat_pos_count", longint'(Count), 300);
    chk("sat_pos_ovf", longint'(Ovf), 1);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("ovf_cleared", longint'(Ovf), 0);
    // negative saturation
    step(0, 1, 1, 0, 1, 0, MINP);
    for (int i = 0; i < 298; i++) step(0, 1, 0, 0, 1, 0, MINP);
    step(0, 1, 0, 1, 1, 0, MINP);
    chk("sat_neg_sum", longint'($signed(Sum)), MINV);
    chk("sat_neg_ovf", longint'(Ovf), 1);
    step(0, 0, 0, 0, 1, 1, 0);
    // term counter saturates at all-ones
    step(0, 1, 1, 0, 1, 0, 1);
    for (int i = 0; i < 65535; i++) step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 1, 0, 0);
    chk("cnt_sat_count", longint'(Count), 65535);
    chk("cnt_sat_sum", longint'($signed(Sum)), 1);
    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [39:0] r40;
      longint p;
      int k;
      k = $urandom_range(0, 3);
      r40 = {$urandom, $urandom};
      p = (k == 0) ? (i % 1000 < 500 ? MAXP : MINP) : (k == 1) ? MAXP : longint'($signed(r40));
      if (k == 2 && i % 2 == 0) p = MINP;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 399) == 0 || !m_open && $urandom_range(0, 9) == 0,
           $urandom_range(0, 299) == 0 || !m_open && $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, p);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
